// File: rtl/core_pkg.sv
// Shared core constants and register-file types, used by decode, writeback and the register file.
package core_pkg;
  localparam int unsigned DATA_WIDTH  = 16;
  localparam int unsigned INDEX_WIDTH = 5;
  localparam int unsigned NUM_REGS    = 32;

  typedef logic [INDEX_WIDTH-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]  data_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage

// File: rtl/register_file_read_if.sv
// Decode/writeback-facing bundle of the register file: write port, two read ports, issue/flush, stall.
interface register_file_read_if;
  import core_pkg::*;

  reg_idx_t write_index_rf;
  data_t    write_data_rf;
  logic     write_en_rf;
  reg_idx_t read_index_a_id;
  reg_idx_t read_index_b_id;
  logic     read_en_id;
  reg_idx_t issue_index_id;
  logic     issue_en_id;
  logic     flush_id;
  data_t    data_a_rf;
  data_t    data_b_rf;
  logic     stall_rf;

  modport master (
    output write_index_rf, write_data_rf, write_en_rf,
    output read_index_a_id, read_index_b_id, read_en_id,
    output issue_index_id, issue_en_id, flush_id,
    input  data_a_rf, data_b_rf, stall_rf
  );

  modport slave (
    input  write_index_rf, write_data_rf, write_en_rf,
    input  read_index_a_id, read_index_b_id, read_en_id,
    input  issue_index_id, issue_en_id, flush_id,
    output data_a_rf, data_b_rf, stall_rf
  );
endinterface

// File: rtl/register_file_read_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback, wiped on flush.
module register_scoreboard
  import core_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     issue_en_i,
  input  reg_idx_t issue_index_i,
  input  logic     flush_i,
  input  logic     write_en_i,
  input  reg_idx_t write_index_i,
  input  reg_idx_t lookup_a_i,
  input  reg_idx_t lookup_b_i,
  output logic     pend_a_o,
  output logic     pend_b_o
);
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Clear before set so a same-index issue (younger instruction) wins over the writeback.
  always_comb begin
    pending_d = pending_q;
    if (write_en_i) pending_d[write_index_i] = 1'b0;
    if (flush_i) begin
      pending_d = '0;
    end else if (issue_en_i && (issue_index_i != ZERO_REG)) begin
      pending_d[issue_index_i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // A write landing this cycle is bypassed to the reader, so it masks the hazard.
  always_comb begin
    pend_a_o = pending_q[lookup_a_i] && !(write_en_i && (write_index_i == lookup_a_i));
    pend_b_o = pending_q[lookup_b_i] && !(write_en_i && (write_index_i == lookup_b_i));
  end
endmodule

// File: rtl/register_file_read.sv
// 32 x 16-bit register file with hardwired r0, two registered read ports with write bypass, and RAW stall.
module register_file_read
  import core_pkg::*;
(
  input logic                clk,
  input logic                reset,
  register_file_read_if.slave rf
);
  data_t regs_q [NUM_REGS];
  data_t data_a_q, data_b_q;
  data_t data_a_d, data_b_d;
  logic  pend_a, pend_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (rf.write_en_rf && (rf.write_index_rf != ZERO_REG)) begin
      regs_q[rf.write_index_rf] <= rf.write_data_rf;
    end
  end

  always_comb begin
    data_a_d = regs_q[rf.read_index_a_id];
    if (rf.write_en_rf && (rf.write_index_rf == rf.read_index_a_id)) data_a_d = rf.write_data_rf;
    if (rf.read_index_a_id == ZERO_REG) data_a_d = '0;

    data_b_d = regs_q[rf.read_index_b_id];
    if (rf.write_en_rf && (rf.write_index_rf == rf.read_index_b_id)) data_b_d = rf.write_data_rf;
    if (rf.read_index_b_id == ZERO_REG) data_b_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_a_q <= '0;
      data_b_q <= '0;
    end else if (rf.read_en_id) begin
      data_a_q <= data_a_d;
      data_b_q <= data_b_d;
    end
  end

  register_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .issue_en_i    (rf.issue_en_id),
    .issue_index_i (rf.issue_index_id),
    .flush_i       (rf.flush_id),
    .write_en_i    (rf.write_en_rf),
    .write_index_i (rf.write_index_rf),
    .lookup_a_i    (rf.read_index_a_id),
    .lookup_b_i    (rf.read_index_b_id),
    .pend_a_o      (pend_a),
    .pend_b_o      (pend_b)
  );

  assign rf.data_a_rf = data_a_q;
  assign rf.data_b_rf = data_b_q;
  assign rf.stall_rf  = rf.read_en_id &&
                        (((rf.read_index_a_id != ZERO_REG) && pend_a) ||
                         ((rf.read_index_b_id != ZERO_REG) && pend_b));
endmodule
